// File: rtl/line_raster_stream.sv
// Bresenham line rasteriser: takes one (x0,y0)->(x1,y1) command and streams its
// pixels one per cycle over a valid/ready interface, with abort and endpoint exclusion.
module line_raster_stream #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          start,
  input  logic [CW-1:0] x0,
  input  logic [CW-1:0] y0,
  input  logic [CW-1:0] x1,
  input  logic [CW-1:0] y1,
  input  logic          include_last,
  input  logic          abort,
  output logic          busy,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          pix_last,
  output logic          done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [1:0]           state;
  logic [CW-1:0]        cur_x, cur_y, end_x, end_y;
  logic signed [CW+1:0] dx_r, dy_r, err_r;
  logic                 sx_neg, sy_neg, incl_r;

  logic signed [CW+1:0] diff_x, diff_y, dx_in, dy_in, err_next;
  logic signed [CW+2:0] e2, dx_ext, dy_ext;
  logic                 step_x, step_y, accept, zero_len;
  logic [CW-1:0]        nx, ny;

  // Command-side setup: magnitudes and step directions from the raw endpoints.
  always_comb begin
    diff_x   = signed'({2'b00, x1}) - signed'({2'b00, x0});
    diff_y   = signed'({2'b00, y1}) - signed'({2'b00, y0});
    dx_in    = diff_x[CW+1] ? -diff_x : diff_x;
    dy_in    = diff_y[CW+1] ? diff_y : -diff_y;
    zero_len = (x0 == x1) && (y0 == y1) && !include_last;
  end

  // NOTE: every signal gets a value on every path through always_comb, so no latch is inferred.
  always_comb begin
    e2       = {err_r, 1'b0};
    dx_ext   = {dx_r[CW+1], dx_r};
    dy_ext   = {dy_r[CW+1], dy_r};
    step_x   = (e2 >= dy_ext);
    step_y   = (e2 <= dx_ext);
    err_next = err_r + (step_x ? dy_r : '0) + (step_y ? dx_r : '0);
    nx       = cur_x;
    ny       = cur_y;
    if (step_x) nx = sx_neg ? cur_x - ONE : cur_x + ONE;
    if (step_y) ny = sy_neg ? cur_y - ONE : cur_y + ONE;
  end

  assign busy      = (state != S_IDLE);
  assign pix_valid = (state == S_RUN);
  assign done      = (state == S_DONE);
  assign pix_x     = cur_x;
  assign pix_y     = cur_y;
  assign accept    = pix_valid && pix_ready;

  // With the endpoint excluded, the final beat is the one whose next step lands on it.
  assign pix_last = pix_valid &&
                    (incl_r ? ((cur_x == end_x) && (cur_y == end_y))
                            : ((nx == end_x) && (ny == end_y)));

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state  <= S_IDLE;
      cur_x  <= '0;
      cur_y  <= '0;
      end_x  <= '0;
      end_y  <= '0;
      dx_r   <= '0;
      dy_r   <= '0;
      err_r  <= '0;
      sx_neg <= 1'b0;
      sy_neg <= 1'b0;
      incl_r <= 1'b0;
    end else if (abort) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cur_x  <= x0;
            cur_y  <= y0;
            end_x  <= x1;
            end_y  <= y1;
            dx_r   <= dx_in;
            dy_r   <= dy_in;
            err_r  <= dx_in + dy_in;
            sx_neg <= diff_x[CW+1];
            sy_neg <= diff_y[CW+1];
            incl_r <= include_last;
            state  <= zero_len ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (accept) begin
            cur_x <= nx;
            cur_y <= ny;
            err_r <= err_next;
            if (pix_last) state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_raster_stream.sv
// Self-checking bench for line_raster_stream: directed cases with literal pixel lists,
// random lines checked against an integer Bresenham reference, abort and reset cases.
module tb_line_raster_stream;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          start, include_last, abort, pix_ready;
  logic [CW-1:0] x0, y0, x1, y1;
  logic          busy, pix_valid, pix_last, done;
  logic [CW-1:0] pix_x, pix_y;

  int checks = 0;
  int errors = 0;
  logic [CW-1:0] exp_x[$];
  logic [CW-1:0] exp_y[$];
  bit            pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  line_raster_stream #(.CW(CW)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .include_last(include_last), .abort(abort), .busy(busy), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y), .pix_last(pix_last), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push(input int px, input int py);
    exp_x.push_back(CW'(px));
    exp_y.push_back(CW'(py));
  endtask

  // Reference: walk the line with integer Bresenham and keep max(dx,|dy|)+incl points.
  task automatic build_model(input int ax0, input int ay0, input int ax1, input int ay1,
                             input bit incl);
    int dx, dy, sx, sy, err, e2, n, px, py;
    exp_x.delete();
    exp_y.delete();
    dx  = (ax1 >= ax0) ? ax1 - ax0 : ax0 - ax1;
    dy  = (ay1 >= ay0) ? ay0 - ay1 : ay1 - ay0;
    sx  = (ax1 >= ax0) ? 1 : -1;
    sy  = (ay1 >= ay0) ? 1 : -1;
    err = dx + dy;
    n   = ((dx > -dy) ? dx : -dy) + (incl ? 1 : 0);
    px  = ax0;
    py  = ay0;
    for (int i = 0; i < n; i++) begin
      push(px, py);
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; px += sx; end
      if (e2 <= dx) begin err += dx; py += sy; end
    end
  endtask

  task automatic issue_start(input int ax0, input int ay0, input int ax1, input int ay1,
                             input bit incl);
    @(negedge clk);
    x0 = CW'(ax0); y0 = CW'(ay0); x1 = CW'(ax1); y1 = CW'(ay1);
    include_last = incl;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    x0 = CW'($urandom); y0 = CW'($urandom); x1 = CW'($urandom); y1 = CW'($urandom);
    include_last = ~incl;
  endtask

  // rmode 0: ready always high; 1: fixed 1,0,0,1,0,1 pattern; 2: random ready.
  task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1,
                          input bit incl, input int rmode, input bit poke);
    int n, idx, cyc, budget;
    bit stalled;
    logic [CW-1:0] prev_x, prev_y;
    logic prev_last;
    n = exp_x.size();
    idx = 0; cyc = 0; budget = 8 * n + 32; stalled = 1'b0;
    prev_x = '0; prev_y = '0; prev_last = 1'b0;
    issue_start(ax0, ay0, ax1, ay1, incl);
    check("busy_after_start", busy, 1);
    while (idx < n && cyc < budget) begin
      case (rmode)
        0:       pix_ready = 1'b1;
        1:       pix_ready = pat[cyc % 6];
        default: pix_ready = 1'($urandom_range(0, 1));
      endcase
      if (poke && cyc == 3) begin
        start = 1'b1;
        x0 = CW'($urandom); y0 = CW'($urandom); x1 = CW'($urandom); y1 = CW'($urandom);
      end else begin
        start = 1'b0;
      end
      check("pix_valid", pix_valid, 1);
      check("pix_x", pix_x, exp_x[idx]);
      check("pix_y", pix_y, exp_y[idx]);
      check("pix_last", pix_last, 32'(idx == n - 1));
      check("done_early", done, 0);
      if (stalled) begin
        check("stall_x", pix_x, prev_x);
        check("stall_y", pix_y, prev_y);
        check("stall_last", pix_last, prev_last);
      end
      stalled = pix_valid && !pix_ready;
      prev_x = pix_x; prev_y = pix_y; prev_last = pix_last;
      if (pix_valid && pix_ready) idx++;
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    pix_ready = 1'b1;
    if (idx < n) check("beat_timeout", idx, n);
    check("done_pulse", done, 1);
    check("valid_in_done", pix_valid, 0);
    check("busy_in_done", busy, 1);
    @(negedge clk);
    check("done_cleared", done, 0);
    check("idle_after_done", busy, 0);
  endtask

  initial begin
    int rx0, ry0, rx1, ry1;
    bit rincl;
    n_rst = 1'b0; start = 1'b0; abort = 1'b0; pix_ready = 1'b1; include_last = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_valid", pix_valid, 0);
    check("rst_last", pix_last, 0);
    check("rst_done", done, 0);
    check("rst_x", pix_x, 0);
    check("rst_y", pix_y, 0);
    @(negedge clk);
    n_rst = 1'b1;

    // Horizontal run
    exp_x.delete(); exp_y.delete();
    for (int i = 0; i <= 5; i++) push(i, 0);
    run_line(0, 0, 5, 0, 1'b1, 0, 1'b0);

    // Diagonal
    exp_x.delete(); exp_y.delete();
    for (int i = 0; i <= 3; i++) push(i, i);
    run_line(0, 0, 3, 3, 1'b1, 0, 1'b0);

    // Leftward shallow line, endpoint excluded
    exp_x.delete(); exp_y.delete();
    push(7, 0); push(6, 0); push(5, 1); push(4, 1); push(3, 2); push(2, 2); push(1, 3);
    run_line(7, 0, 0, 3, 1'b0, 0, 1'b0);

    // Single point, included and excluded
    exp_x.delete(); exp_y.delete();
    push(2, 2);
    run_line(2, 2, 2, 2, 1'b1, 0, 1'b0);
    exp_x.delete(); exp_y.delete();
    run_line(2, 2, 2, 2, 1'b0, 0, 1'b0);

    // Backpressure pattern
    exp_x.delete(); exp_y.delete();
    push(0, 0); push(1, 1); push(2, 1); push(3, 2); push(4, 2);
    run_line(0, 0, 4, 2, 1'b1, 1, 1'b0);

    // Abort on the third beat of a full-range diagonal
    build_model(255, 255, 0, 0, 1'b1);
    issue_start(255, 255, 0, 0, 1'b1);
    pix_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("abort_pre_x", pix_x, exp_x[i]);
      check("abort_pre_y", pix_y, exp_y[i]);
      if (i == 2) abort = 1'b1;
      @(negedge clk);
    end
    abort = 1'b0;
    check("abort_valid", pix_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
    end

    // Abort wins over start in IDLE
    x0 = 8'd1; y0 = 8'd1; x1 = 8'd9; y1 = 8'd9; include_last = 1'b1;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("abort_over_start", busy, 0);

    // Restart full line; a start mid-line must be ignored
    build_model(255, 255, 0, 0, 1'b1);
    check("model_len_256", exp_x.size(), 256);
    run_line(255, 255, 0, 0, 1'b1, 0, 1'b1);

    // Asynchronous reset mid-line
    issue_start(0, 0, 200, 100, 1'b1);
    repeat (4) @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_valid", pix_valid, 0);
    check("arst_done", done, 0);
    check("arst_x", pix_x, 0);
    check("arst_y", pix_y, 0);
    @(negedge clk);
    n_rst = 1'b1;

    // Random lines under random backpressure
    for (int t = 0; t < 24; t++) begin
      rx0 = $urandom_range(0, 255);
      ry0 = $urandom_range(0, 255);
      if (t % 2 == 0) begin
        rx1 = $urandom_range(0, 255);
        ry1 = $urandom_range(0, 255);
      end else begin
        rx1 = $urandom_range(0, 255) % 16 + ((rx0 > 8) ? rx0 - 8 : 0);
        ry1 = $urandom_range(0, 255) % 16 + ((ry0 > 8) ? ry0 - 8 : 0);
        if (rx1 > 255) rx1 = 255;
        if (ry1 > 255) ry1 = 255;
      end
      rincl = 1'($urandom_range(0, 1));
      build_model(rx0, ry0, rx1, ry1, rincl);
      run_line(rx0, ry0, rx1, ry1, rincl, 2, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
